// File: rtl/seq_detect_moore_param.sv
// Parametrised Moore serial sequence detector with runtime-loadable pattern, length and
// overlap mode, a valid-qualified input stream and a saturating match counter.
module seq_detect_moore_param #(
   parameter int unsigned MAX_LEN = 8,
   parameter int unsigned LEN_W   = $clog2(MAX_LEN) + 1,
   parameter int unsigned CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               inp,
   output logic               out,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   typedef enum logic [1:0] {StIdle, StFill, StHunt, StHit} state_e;

   state_e             state_q;
   logic [MAX_LEN-1:0] pattern_q;
   logic [LEN_W-1:0]   len_q;
   logic               overlap_q;
   // Only MAX_LEN-1 history bits are stored: the oldest bit of a full-length window is
   // the stored MSB, and the newest is the incoming bit itself.
   logic [MAX_LEN-2:0] hist_q;
   logic [LEN_W-1:0]   bits_seen_q;
   logic               out_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               cfg_err_q;

   logic [MAX_LEN-1:0] hist_shift;
   logic [MAX_LEN-1:0] len_mask;
   logic [31:0]        len_ext;
   logic [LEN_W:0]     seen_inc;
   logic               fill_done;
   logic               pat_eq;
   logic               hit;
   logic [LEN_W-1:0]   seen_next;
   logic               cfg_legal;
   logic [CNT_W-1:0]   cnt_inc;

   always_comb begin
      hist_shift = {hist_q, inp};
      len_ext    = 32'(len_q);
      len_mask   = '0;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < len_ext);
      end
      seen_inc  = {1'b0, bits_seen_q} + (LEN_W + 1)'(1);
      fill_done = (seen_inc >= {1'b0, len_q});
      pat_eq    = (((hist_shift ^ pattern_q) & len_mask) == '0);
      hit       = fill_done && pat_eq;

      // Non-overlapping mode restarts the fill after every match.
      if (hit && !overlap_q) begin
         seen_next = '0;
      end else if (seen_inc <= {1'b0, len_q}) begin
         seen_next = seen_inc[LEN_W-1:0];
      end else begin
         seen_next = bits_seen_q;
      end

      cfg_legal = (cfg_len != '0) && (32'(cfg_len) <= MAX_LEN);
      cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= StIdle;
         pattern_q   <= '0;
         len_q       <= '0;
         overlap_q   <= 1'b0;
         hist_q      <= '0;
         bits_seen_q <= '0;
         out_q       <= 1'b0;
         cnt_q       <= '0;
         cfg_err_q   <= 1'b0;
      end else if (cfg_load) begin
         hist_q      <= '0;
         bits_seen_q <= '0;
         out_q       <= 1'b0;
         if (cfg_legal) begin
            pattern_q <= cfg_pattern;
            len_q     <= cfg_len;
            overlap_q <= cfg_overlap;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            state_q   <= StFill;
         end else begin
            cfg_err_q <= 1'b1;
            state_q   <= StIdle;
         end
      end else if (in_valid && (state_q != StIdle)) begin
         hist_q      <= hist_shift[MAX_LEN-2:0];
         bits_seen_q <= seen_next;
         if (hit) begin
            state_q <= StHit;
            out_q   <= 1'b1;
            cnt_q   <= cnt_inc;
         end else if (!fill_done) begin
            state_q <= StFill;
            out_q   <= 1'b0;
         end else begin
            state_q <= StHunt;
            out_q   <= 1'b0;
         end
      end
   end

   assign out         = out_q;
   assign match_count = cnt_q;
   assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// Bench for seq_detect_moore_param: directed scenarios plus random streams, checked against a
// queue-based model of the matching rules; a second instance exercises a 2-bit counter.
module tb_seq_detect_moore_param;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = '0;
   logic [3:0] cfg_len = '0;
   logic       cfg_overlap = 1'b0;
   logic       in_valid = 1'b0;
   logic       inp = 1'b0;

   logic       out_a, err_a, out_b, err_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;

   int errors = 0;
   int checks = 0;
   string phase = "reset";

   seq_detect_moore_param u_dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .inp(inp),
      .out(out_a), .match_count(cnt_a), .cfg_err(err_a)
   );

   seq_detect_moore_param #(.CNT_W(2)) u_dut_c2 (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .inp(inp),
      .out(out_b), .match_count(cnt_b), .cfg_err(err_b)
   );

   always #5 clk = ~clk;

   // Reference model: list of accepted bits, count of bits since load or last non-overlap hit.
   bit       m_active = 0;
   bit       m_ov = 0;
   bit [7:0] m_pat = '0;
   int       m_len = 0;
   bit       m_q[$];
   int       m_fresh = 0;
   bit       m_out = 0;
   bit       m_err = 0;
   int       m_cnt8 = 0;
   int       m_cnt2 = 0;

   task automatic model_edge();
      bit match;
      if (!rst) begin
         m_active = 0; m_ov = 0; m_pat = '0; m_len = 0; m_q.delete(); m_fresh = 0;
         m_out = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
      end else if (cfg_load) begin
         m_q.delete(); m_fresh = 0; m_out = 0; m_active = 0;
         if (cfg_len == 0 || cfg_len > 8) begin
            m_err = 1;
         end else begin
            m_err = 0; m_active = 1; m_pat = cfg_pattern; m_len = int'(cfg_len);
            m_ov = cfg_overlap; m_cnt8 = 0; m_cnt2 = 0;
         end
      end else if (in_valid && m_active) begin
         m_q.push_back(inp);
         if (m_q.size() > 16) void'(m_q.pop_front());
         m_fresh++;
         match = (m_fresh >= m_len);
         if (match) begin
            // Newest bit pairs with pattern bit 0, oldest of the window with bit len-1.
            for (int k = 0; k < m_len; k++) begin
               if (m_q[m_q.size() - 1 - k] != m_pat[k]) match = 0;
            end
         end
         m_out = match;
         if (match) begin
            if (m_cnt8 < 255) m_cnt8++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!m_ov) m_fresh = 0;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s/%s: got %0h expected %0h", phase, tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("out", 32'(out_a), 32'(m_out));
      chk("count", 32'(cnt_a), 32'(m_cnt8));
      chk("cfg_err", 32'(err_a), 32'(m_err));
      chk("out_c2", 32'(out_b), 32'(m_out));
      chk("count_c2", 32'(cnt_b), 32'(m_cnt2));
      chk("cfg_err_c2", 32'(err_b), 32'(m_err));
   endtask

   task automatic step(input bit ld, input logic [7:0] pat, input logic [3:0] len, input bit ov,
                       input bit v, input bit b);
      cfg_load = ld; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
      in_valid = v; inp = b;
      @(posedge clk);
      model_edge();
      #1;
      cfg_load = 1'b0; in_valid = 1'b0;
      check_all();
   endtask

   task automatic beat(input bit b);
      step(1'b0, 8'h00, 4'd0, 1'b0, 1'b1, b);
   endtask

   task automatic idle();
      step(1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [7:0] pat, input logic [3:0] len, input bit ov);
      step(1'b1, pat, len, ov, 1'b0, 1'b0);
   endtask

   // Sends n bits, first bit taken from bits[n-1].
   task automatic stream(input logic [31:0] bits, input int n);
      for (int i = n - 1; i >= 0; i--) beat(bits[i]);
   endtask

   task automatic pulse_reset();
      rst = 1'b0;
      idle();
      rst = 1'b1;
   endtask

   initial begin
      logic [3:0] rl;
      rst = 1'b0;
      idle();
      idle();
      rst = 1'b1;

      phase = "idle_beats";
      repeat (10) beat(1'($urandom_range(0, 1)));
      chk("idle_count", 32'(cnt_a), 32'd0);
      chk("idle_out", 32'(out_a), 32'd0);

      phase = "p03_overlap";
      load(8'h03, 4'd4, 1'b1);
      stream(32'b00110011, 8);
      chk("count_after_8", 32'(cnt_a), 32'd2);

      phase = "p0a_overlap";
      load(8'h0A, 4'd4, 1'b1);
      stream(32'b101010, 6);
      chk("count_ov", 32'(cnt_a), 32'd2);
      phase = "p0a_nonoverlap";
      load(8'h0A, 4'd4, 1'b0);
      stream(32'b101010, 6);
      chk("count_nov", 32'(cnt_a), 32'd1);

      phase = "hit_hold";
      load(8'h0A, 4'd4, 1'b1);
      stream(32'b1010, 4);
      repeat (5) idle();
      chk("held_out", 32'(out_a), 32'd1);
      beat(1'b1);
      chk("drop_out", 32'(out_a), 32'd0);

      phase = "illegal_cfg";
      load(8'hFF, 4'd0, 1'b0);
      chk("len0_err", 32'(err_a), 32'd1);
      stream(32'b1111, 4);
      load(8'hFF, 4'd9, 1'b1);
      chk("len9_err", 32'(err_a), 32'd1);
      stream(32'b1111, 4);
      chk("ignored_out", 32'(out_a), 32'd0);

      phase = "load_drops_bit";
      step(1'b1, 8'h03, 4'd4, 1'b1, 1'b1, 1'b0);
      chk("legal_clears_err", 32'(err_a), 32'd0);
      stream(32'b011, 3);
      chk("dropped_no_hit", 32'(out_a), 32'd0);
      beat(1'b1);

      phase = "len8_and_len1";
      load(8'hA5, 4'd8, 1'b0);
      stream(32'b10100101, 8);
      chk("len8_hit", 32'(out_a), 32'd1);
      load(8'h01, 4'd1, 1'b1);
      stream(32'b1101, 4);
      chk("len1_count", 32'(cnt_a), 32'd3);

      phase = "reset_in_hit";
      load(8'h03, 4'd4, 1'b1);
      stream(32'b001100110011, 12);
      chk("pre_reset_count", 32'(cnt_a), 32'd3);
      chk("pre_reset_out", 32'(out_a), 32'd1);
      pulse_reset();
      chk("post_reset_out", 32'(out_a), 32'd0);
      chk("post_reset_count", 32'(cnt_a), 32'd0);
      stream(32'b0011, 4);
      chk("post_reset_idle", 32'(out_a), 32'd0);

      phase = "saturate_c2";
      load(8'h03, 4'd4, 1'b1);
      stream(32'b00110011001100110011, 20);
      chk("count_c2_sat", 32'(cnt_b), 32'd3);
      chk("count_wide", 32'(cnt_a), 32'd5);

      phase = "random";
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            rl = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(9, 15));
         end else if ($urandom_range(0, 4) == 0) begin
            rl = 4'($urandom_range(5, 8));
         end else begin
            rl = 4'($urandom_range(1, 4));
         end
         step(1'b1, 8'($urandom), rl, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int s = 0; s < 40; s++) begin
            if ($urandom_range(0, 199) == 0) begin
               pulse_reset();
            end else begin
               step(1'b0, 8'h00, 4'd0, 1'b0, ($urandom_range(0, 9) < 7),
                    1'($urandom_range(0, 1)));
            end
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/seq_detect_moore_param.md
Name: seq_detect_moore_param

Overview:
Parametrised Moore-type serial sequence detector, successor to the fixed 4-bit pattern detector FSM.
- Pattern bits, pattern length and overlap mode are runtime-loadable.
- Input is qualified by a valid strobe.
- A saturating match counter is kept.
- Sits on a 1-bit serial stream inside control/protocol logic; out drives downstream event logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..32).
LEN_W, $clog2(MAX_LEN)+1, width of cfg_len.
CNT_W, 8, width of match_count.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-low reset (rst==0 at a rising clk edge resets the block).
cfg_load  input  1  one-cycle strobe; latch cfg_pattern/cfg_len/cfg_overlap.
cfg_pattern  input  MAX_LEN  pattern; bits [cfg_len-1:0] used; bit [cfg_len-1] is the first serial bit expected.
cfg_len  input  LEN_W  pattern length, legal 1..MAX_LEN.
cfg_overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
in_valid  input  1  inp is sampled only when 1.
inp  input  1  serial data bit.
out  output  1  Moore match flag, 1 only in state HIT.
match_count  output  CNT_W  number of matches since reset/load, saturating.
cfg_err  output  1  last cfg_load had illegal length.

Behaviour:
Reset (rst==0 at clk edge):
- State IDLE.
- out=0, match_count=0, cfg_err=0.
- Pattern, length, overlap and history registers cleared; bits_seen=0.
- Reset has priority over every other input.

Internal state:
- hist[MAX_LEN-1:0]: shift register of accepted bits; newest bit enters at bit 0.
- bits_seen: saturates at the latched length.
- FSM states: IDLE, FILL, HUNT, HIT.

Config load (cfg_load==1, rst==1):
- Priority over in_valid; a bit presented in the same cycle is dropped.
- If cfg_len==0 or cfg_len>MAX_LEN: cfg_err=1, state IDLE, registers unchanged except hist/bits_seen cleared.
- Otherwise: latch config, cfg_err=0, hist=0, bits_seen=0, match_count=0, state FILL.

Accepted beat (in_valid==1, no cfg_load):
- hist <= {hist[MAX_LEN-2:0], inp}.
- bits_seen increments, saturating at len.
- hit condition: (bits_seen+1 >= len) and the new hist[len-1:0] == pattern[len-1:0].
- Transitions from any non-IDLE state:
  - hit -> HIT.
  - else bits_seen+1 < len -> FILL.
  - else -> HUNT.

Non-overlap mode:
- On entering HIT, bits_seen is cleared to 0.
- The next match needs len fresh bits.

Overlap mode:
- bits_seen stays at len.
- The next match may complete on any following beat.

IDLE:
- in_valid beats are ignored.
- Leaves only by a legal cfg_load.

No accepted beat: state, hist, out unchanged. HIT holds across in_valid gaps.

Output and counter:
- out = (state==HIT); registered Moore output.
- The completing bit sampled at edge N gives out=1 in the cycle after edge N.
- match_count increments on each entry into HIT, including HIT->HIT; saturates at 2^CNT_W-1.

Test Plan:
1. Release rst, no cfg_load, 10 random valid beats -> out=0, match_count=0 throughout (IDLE).
2. Load pattern=8'h03, len=4, overlap=1; stream 0,0,1,1,0,0,1,1 -> out=1 after beats 4 and 8 only, match_count=2.
3. Load pattern=8'h0A, len=4; stream 1,0,1,0,1,0 -> overlap=1: hits at beats 4 and 6, count=2; overlap=0: hit at beat 4 only, count=1.
4. After a hit, hold in_valid=0 for 5 cycles -> out stays 1; next beat non-matching -> out=0 next cycle.
5. cfg_load with cfg_len=0, then with cfg_len=9 (MAX_LEN=8) -> cfg_err=1, IDLE, beats ignored. cfg_load and in_valid in the same cycle -> bit dropped, bits_seen=0.
6. Drive rst=0 for one edge while in HIT with count=3 -> out=0, match_count=0, IDLE. With CNT_W=2, 5 matches -> match_count stays 3.
